// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM states,
// datapath select encodings and the immediate-format decode.
package mc_pkg;

  localparam int OP_W    = 7;
  localparam int STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] immSrcFor(input logic [OP_W-1:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic isKnownOp(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_state_outputs.sv
// Combinational Moore output decode for the controller; zero latency.
// Only FETCH, MEMWRITE and BEQ look at mem_ready/zero; all else is state-only.
module mc_state_outputs
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       memReady,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       instrDone
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic     illegalOp
`endif
);

  logic pcUpdate;
  logic branch;

  always_comb begin
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    instrDone = 1'b0;
    case (state)
      FETCH: begin
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_FOUR;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALURESULT;
        irWrite   = memReady;
        pcUpdate  = memReady;
      end
      DECODE: begin
        // Branch target computed speculatively into ALUOut
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        adrSrc    = 1'b1;
        resultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        resultSrc = RES_DATA;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      MEMWRITE: begin
        adrSrc    = 1'b1;
        resultSrc = RES_ALUOUT;
        memWrite  = 1'b1;
        instrDone = memReady;
      end
      EXECUTER: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_RD2;
        aluOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        resultSrc = RES_ALUOUT;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      BEQ: begin
        aluSrcA   = SRCA_RD1;
        aluSrcB   = SRCB_RD2;
        aluOp     = ALUOP_SUB;
        resultSrc = RES_ALUOUT;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        aluOp     = ALUOP_ADD;
        resultSrc = RES_ALUOUT;
        pcUpdate  = 1'b1;
      end
      default: ;
    endcase
    pcWrite = pcUpdate | (branch & zero);
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegalOp = (state == TRAP);
`endif

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: 3-5 states per instruction, stalls in place on mem_ready=0.
// MC_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP (illegal_op=1) instead of acting as NOP.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ImmSrc,
  output logic            instr_done
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic          illegal_op
`endif
);

  state_t state, stateNext;
  logic   pcWriteS, memWriteS, irWriteS, regWriteS, doneS, nopDone;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = FETCH;
    case (state)
      FETCH:    stateNext = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_R:         stateNext = EXECUTER;
          OP_I:         stateNext = EXECUTEI;
          OP_BEQ:       stateNext = BEQ;
          OP_JAL:       stateNext = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      stateNext = TRAP;
`else
          default:      stateNext = FETCH;
`endif
        endcase
      end
      MEMADR:   stateNext = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  stateNext = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    stateNext = FETCH;
      MEMWRITE: stateNext = mem_ready ? FETCH : MEMWRITE;
      EXECUTER: stateNext = ALUWB;
      EXECUTEI: stateNext = ALUWB;
      ALUWB:    stateNext = FETCH;
      BEQ:      stateNext = FETCH;
      JAL:      stateNext = ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP:     stateNext = TRAP;
`endif
      default:  stateNext = FETCH;
    endcase
  end

  mc_state_outputs u_outputs (
    .state     (state),
    .memReady  (mem_ready),
    .zero      (zero),
    .pcWrite   (pcWriteS),
    .adrSrc    (AdrSrc),
    .memWrite  (memWriteS),
    .irWrite   (irWriteS),
    .regWrite  (regWriteS),
    .resultSrc (ResultSrc),
    .aluSrcA   (ALUSrcA),
    .aluSrcB   (ALUSrcB),
    .aluOp     (ALUOp),
    .instrDone (doneS)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegalOp (illegal_op)
`endif
  );

`ifdef MC_ILLEGAL_TRAP_EN
  assign nopDone = 1'b0;
`else
  assign nopDone = (state == DECODE) && !isKnownOp(op);
`endif

  // Strobes are masked by rst itself so nothing commits while reset is held
  assign PCWrite    = rst & pcWriteS;
  assign MemWrite   = rst & memWriteS;
  assign IRWrite    = rst & irWriteS;
  assign RegWrite   = rst & regWriteS;
  assign instr_done = rst & (doneS | nopDone);
  assign ImmSrc     = immSrcFor(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; each cycle compares the full
// control-output vector against a hand-derived expectation.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ImmSrc     (ImmSrc),
    .instr_done (instr_done)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_op (illegal_op)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [15:0] outs;
  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc instr_done
  function automatic logic [15:0] mk(input int pcw, input int adr, input int mw, input int irw,
                                     input int rw, input int rs, input int sa, input int sb,
                                     input int aop, input int imm, input int done);
    return {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
            2'(aop), 2'(imm), 1'(done)};
  endfunction

  function automatic logic [15:0] vFetch(input int imm, input int mr);
    return mk(mr, 0, 0, mr, 0, 2, 0, 2, 0, imm, 0);
  endfunction

  function automatic logic [15:0] vDecode(input int imm, input int done);
    return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, imm, done);
  endfunction

  // Apply inputs just after an edge, check before the next one, then advance.
  task automatic cyc(input string tag, input logic [6:0] o, input logic mr, input logic z,
                     input logic [15:0] exp);
    op = o; mem_ready = mr; zero = z;
    #1;
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset_hold", outs, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // lw, no stalls: 5 cycles
    cyc("lw.fetch",   LW, 1, 0, vFetch(0, 1));
    cyc("lw.decode",  LW, 1, 0, vDecode(0, 0));
    cyc("lw.memadr",  LW, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    cyc("lw.memread", LW, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw.memwb",   LW, 1, 0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

    // lw with one stall in FETCH and one in MEMREAD
    cyc("lws.fetch0",   LW, 0, 0, vFetch(0, 0));
    cyc("lws.fetch1",   LW, 1, 0, vFetch(0, 1));
    cyc("lws.decode",   LW, 1, 0, vDecode(0, 0));
    cyc("lws.memadr",   LW, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    cyc("lws.memread0", LW, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lws.memread1", LW, 1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lws.memwb",    LW, 1, 0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1));

    // sw with two stall cycles in MEMWRITE: 6 cycles, MemWrite held 3
    cyc("sw.fetch",     SW, 1, 0, vFetch(1, 1));
    cyc("sw.decode",    SW, 1, 0, vDecode(1, 0));
    cyc("sw.memadr",    SW, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    cyc("sw.memwrite0", SW, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("sw.memwrite1", SW, 0, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("sw.memwrite2", SW, 1, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));

    // beq taken, then not taken
    cyc("beqT.fetch",  BQ, 1, 0, vFetch(2, 1));
    cyc("beqT.decode", BQ, 1, 0, vDecode(2, 0));
    cyc("beqT.beq",    BQ, 1, 1, mk(1, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1));
    cyc("beqN.fetch",  BQ, 1, 0, vFetch(2, 1));
    cyc("beqN.decode", BQ, 1, 0, vDecode(2, 0));
    cyc("beqN.beq",    BQ, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 1));

    // R-type
    cyc("r.fetch",  RT, 1, 0, vFetch(0, 1));
    cyc("r.decode", RT, 1, 0, vDecode(0, 0));
    cyc("r.exec",   RT, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    cyc("r.aluwb",  RT, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    // I-type
    cyc("i.fetch",  IT, 1, 0, vFetch(0, 1));
    cyc("i.decode", IT, 1, 0, vDecode(0, 0));
    cyc("i.exec",   IT, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0));
    cyc("i.aluwb",  IT, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    // jal
    cyc("jal.fetch",  JL, 1, 0, vFetch(3, 1));
    cyc("jal.decode", JL, 1, 0, vDecode(3, 0));
    cyc("jal.jal",    JL, 1, 0, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 3, 0));
    cyc("jal.aluwb",  JL, 1, 0, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1));

    // Reset asserted mid-MEMWRITE abandons the store
    cyc("swr.fetch",  SW, 1, 0, vFetch(1, 1));
    cyc("swr.decode", SW, 1, 0, vDecode(1, 0));
    cyc("swr.memadr", SW, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    op = SW; mem_ready = 1'b0; zero = 1'b0;
    #1;
    check("swr.memwrite", outs, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    #1;
    rst = 1'b0;
    #1;
    check("swr.rst_async", outs, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
    mem_ready = 1'b1;
    #1;
    check("swr.rst_mr1", outs, mk(0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("swr.fetch0",   SW, 0, 0, vFetch(1, 0));
    cyc("swr.fetch1",   SW, 1, 0, vFetch(1, 1));
    cyc("swr.decode2",  SW, 1, 0, vDecode(1, 0));
    cyc("swr.memadr2",  SW, 1, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
    cyc("swr.memwrite", SW, 1, 0, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));

`ifdef MC_ILLEGAL_TRAP_EN
    cyc("trap.fetch",  BAD, 1, 0, vFetch(0, 1));
    cyc("trap.decode", BAD, 1, 0, vDecode(0, 0));
    for (int i = 0; i < 3; i++) begin
      op = BAD; mem_ready = 1'b1; zero = 1'b1;
      #1;
      check("trap.outs", outs, 16'h0000);
      check("trap.illegal", {15'd0, illegal_op}, 16'h0001);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("trap.rst_clear", {15'd0, illegal_op}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("trap.refetch", LW, 1, 0, vFetch(0, 1));
`else
    cyc("nop.fetch",   BAD, 1, 0, vFetch(0, 1));
    cyc("nop.decode",  BAD, 1, 0, vDecode(0, 1));
    cyc("nop.refetch", BAD, 1, 0, vFetch(0, 1));
    cyc("nop.decode2", LW,  1, 0, vDecode(0, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
